// File: rtl/hermes_rx_buffer_pkg.sv
// -----------------------------------------------------------------------------
// hermes_rx_buffer_pkg
// Shared Hermes router definitions: port count and port identifiers, default
// flit width and FIFO depth, and the receive-side framing FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package hermes_rx_buffer_pkg;

  localparam int NPORT = 5;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } hermes_port_t;

  // Default FIFO depth per input port, in flits (power of two, >= 2).
  localparam int HERMES_BUFFER_SIZE = 8;
  localparam int HERMES_FLIT_SIZE   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    HEADER  = 3'd2,
    SIZE    = 3'd3,
    PAYLOAD = 3'd4
  } hermes_rx_state_t;

  // True in the states where the head flit belongs to a routed packet and
  // may be offered to the crossbar.
  function automatic logic rx_forwarding(input hermes_rx_state_t s);
    return (s == HEADER) || (s == SIZE) || (s == PAYLOAD);
  endfunction

endpackage

// File: rtl/hermes_rx_buffer_fifo.sv
// -----------------------------------------------------------------------------
// hermes_fifo
// Circular flit FIFO for one router input port.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears pointers/count)
//   push_i, data_i write data_i at the tail (ignored when full)
//   pop_i          drop the head flit (ignored when empty)
//   head_o         current head flit, forced to 0 when empty
//   full_o         occupancy == DEPTH
//   empty_o        occupancy == 0
// The head is read asynchronously so a flit written on one edge is visible
// at the head in the very next cycle; storage itself is never reset.
// -----------------------------------------------------------------------------
module hermes_fifo
  import hermes_rx_buffer_pkg::*;
#(
  parameter int WIDTH = HERMES_FLIT_SIZE,
  parameter int DEPTH = HERMES_BUFFER_SIZE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so increment wraps for free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign head_o  = empty_o ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/hermes_rx_buffer.sv
// -----------------------------------------------------------------------------
// hermes_rx_buffer
// Receive buffer for one Hermes router input port: stores incoming flits,
// frames packets (header, size N, N payload flits), requests routing for each
// header and forwards flits to the local crossbar.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   rx_i, data_i     upstream flit valid / flit
//   credit_o         buffer can accept a flit this cycle
//   req_routing_o    header at the head awaits routing
//   routed_i         switch control accepted the routing request
//   data_av_o, data_o  head flit offered to the crossbar (data_o=0 when empty)
//   ack_i            crossbar consumed the head flit
//   sending_o        this packet owns an output port
//   end_o            one-cycle pulse during the cycle the last flit is consumed
//   pkt_cnt_o        (only with HERMES_RX_PKT_CNT_EN) saturating packet count
// Optional feature macro: HERMES_RX_PKT_CNT_EN.
// -----------------------------------------------------------------------------
module hermes_rx_buffer
  import hermes_rx_buffer_pkg::*;
#(
  parameter int FLIT_SIZE   = HERMES_FLIT_SIZE,
  parameter int BUFFER_SIZE = HERMES_BUFFER_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_routing_o,
  input  logic                 routed_i,
  output logic                 data_av_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 ack_i,
  output logic                 sending_o,
  output logic                 end_o
`ifdef HERMES_RX_PKT_CNT_EN
  ,
  output logic [15:0]          pkt_cnt_o
`endif
);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FLIT_SIZE-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 last_pop;

  hermes_rx_state_t     state_reg;
  logic                 req_routing_reg;
  logic                 sending_reg;
  logic [FLIT_SIZE-1:0] payload_cnt_reg;

  hermes_fifo #(
    .WIDTH (FLIT_SIZE),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Credit comes straight from the registered occupancy: a pop in a full
  // cycle does not free a slot until the next cycle.
  assign credit_o  = !fifo_full;
  assign push      = rx_i && credit_o;
  assign data_av_o = rx_forwarding(state_reg) && !fifo_empty;
  assign pop       = data_av_o && ack_i;
  assign data_o    = head;

  // Last flit is either a zero size flit or the payload flit popped with one
  // flit left on the counter.
  assign last_pop = pop &&
                    (((state_reg == SIZE) && (head == '0)) ||
                     ((state_reg == PAYLOAD) && (payload_cnt_reg == FLIT_SIZE'(1))));
  // A reset edge discards the packet, so no end is reported in that cycle.
  assign end_o    = last_pop && !rst_i;

  assign req_routing_o = req_routing_reg;
  assign sending_o     = sending_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      req_routing_reg <= 1'b0;
      sending_reg     <= 1'b0;
      payload_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg       <= REQ;
            req_routing_reg <= 1'b1;
          end
        end
        REQ: begin
          if (routed_i) begin
            state_reg       <= HEADER;
            req_routing_reg <= 1'b0;
            sending_reg     <= 1'b1;
          end
        end
        HEADER: begin
          if (pop) state_reg <= SIZE;
        end
        SIZE: begin
          if (pop) begin
            payload_cnt_reg <= head;
            if (head == '0) begin
              state_reg   <= IDLE;
              sending_reg <= 1'b0;
            end else begin
              state_reg <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (pop) begin
            payload_cnt_reg <= payload_cnt_reg - 1'b1;
            if (last_pop) begin
              state_reg   <= IDLE;
              sending_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg       <= IDLE;
          req_routing_reg <= 1'b0;
          sending_reg     <= 1'b0;
        end
      endcase
    end
  end

`ifdef HERMES_RX_PKT_CNT_EN
  logic [15:0] pkt_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_reg <= '0;
    end else if (end_o && (pkt_cnt_reg != 16'hFFFF)) begin
      pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_reg;
`endif

endmodule

// File: doc/hermes_rx_buffer.md
Name: hermes_rx_buffer

Overview:
- Receiving end of a Hermes router link: per-input-port flit FIFO, accepting flits driven by a neighbour's crossbar output via the rx/credit handshake.
- Frames Hermes packets: header flit, then size flit (payload count N), then N payload flits.
- Requests routing for each header, presents flits to the local crossbar (data_av/ack), and flags packet end so the switch control can release the output port.
- One instance per router input port.

Parameters:
FLIT_SIZE, 32, flit width in bits.
BUFFER_SIZE, 8, FIFO depth in flits; power of two, >= 2.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, synchronous, active-high.
rx_i  in  1  upstream flit valid.
data_i  in  FLIT_SIZE  upstream flit.
credit_o  out  1  FIFO can accept a flit this cycle.
req_routing_o  out  1  header at FIFO head awaits routing.
routed_i  in  1  switch control accepted the routing request.
data_av_o  out  1  flit at head is available to the crossbar.
data_o  out  FLIT_SIZE  head flit.
ack_i  in  1  crossbar consumed the head flit.
sending_o  out  1  packet owns an output port.
end_o  out  1  one-cycle pulse on the last flit's consume.

Behaviour:
- Reset (rst_i high on a clock edge):
  - Pointers and occupancy are cleared; FSM goes to IDLE; payload counter is cleared.
  - Outputs: credit_o=1, req_routing_o=0, data_av_o=0, data_o=0, sending_o=0, end_o=0.
  - Reset mid-packet discards all stored flits; no end_o is issued.
- Write: on a clock edge with rx_i && credit_o, data_i is stored at the tail.
  - credit_o = (count < BUFFER_SIZE); it is combinational from registered count.
  - rx_i while credit_o=0 is ignored (upstream protocol violation).
- Read: on a clock edge with data_av_o && ack_i, the head is popped.
  - ack_i without data_av_o is ignored.
- Same-cycle read and write are both performed; count is unchanged.
  - When full, credit_o=0 in that cycle even if a pop occurs (no fall-through of credit).
- data_o = FIFO head; it is 0 when the FIFO is empty.
- Pointers are log2(BUFFER_SIZE) bits and wrap naturally. count is log2(BUFFER_SIZE)+1 bits.
- FSM states are hermes_rx_state_t:
  - IDLE: if FIFO is non-empty, go to REQ.
  - REQ: req_routing_o=1. On routed_i, drop the request and go to HEADER. sending_o becomes 1 from the next cycle.
  - HEADER: data_av_o = !empty. On pop, go to SIZE.
  - SIZE: data_av_o = !empty. On pop, load the payload counter with the popped flit value (full FLIT_SIZE width).
    - If that value is 0: pulse end_o, clear sending_o, go to IDLE.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: data_av_o = !empty. Each pop decrements the counter.
    - The pop with counter==1 pulses end_o, clears sending_o on the next edge, and goes to IDLE.
- data_av_o=0 in IDLE and REQ.
- Header latency: flit written at edge t is visible at the head at t+1; req_routing_o is high from t+2.
- Back-to-back packets: after end_o, IDLE sees the next header the following cycle. The minimum gap is 1 idle cycle.
- An empty FIFO mid-packet stalls the FSM in its current state. sending_o stays high.

Optional Feature:
- Macro HERMES_RX_PKT_CNT_EN.
- Defined: adds output pkt_cnt_o, 16 bits.
  - Increments on each end_o and saturates at 16'hFFFF.
  - Cleared by rst_i.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- HermesPkg gains typedef enum logic [2:0] hermes_rx_state_t {IDLE, REQ, HEADER, SIZE, PAYLOAD}.
- The HermesPkg FIFO depth default constant lives alongside the NPORT and hermes_port_t definitions.
- One sub-module, hermes_fifo: circular FIFO with push/pop, full/empty and head output. The framing FSM stays in hermes_rx_buffer.

Test Plan:
- Reset, then idle -> credit_o=1, data_av_o=0, req_routing_o=0, sending_o=0.
- Send 0x00000011, 0x2, 0xA, 0xB; assert routed_i 1 cycle after req; ack_i held high -> data_o sequence 0x11, 0x2, 0xA, 0xB; end_o pulses on the 0xB pop; sending_o falls the next cycle.
- BUFFER_SIZE=8, ack_i=0, push 9 flits -> credit_o falls after the 8th; the 9th is not stored; one pop restores credit_o the next cycle.
- Header with size flit 0x0 -> end_o on the size-flit pop; FSM returns to IDLE; a following header raises req_routing_o 2 cycles later.
- Full FIFO with simultaneous rx_i and pop over 20 cycles; push and pop every cycle with wrap-around -> no flit lost or duplicated; order preserved.
- rst_i asserted mid-payload with 3 flits stored -> next cycle count=0, sending_o=0, no end_o.
- With HERMES_RX_PKT_CNT_EN defined, 3 packets -> pkt_cnt_o=3.
